// File: rtl/hamming_serial_rx.sv
// Hamming(7,4) serial receiver: 2-flop input synchronizer, framed
// deserializer (start, c0..c6 LSB first, stop), single-error correction,
// valid/ready output stage with overrun detection and a saturating count
// of corrected words.
module hamming_serial_rx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    output logic [3:0]       data_out,
    output logic [2:0]       syndrome,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic [CNT_W-1:0] corr_count
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic          sync1, line;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [6:0]    code;
    logic          armed;
    logic          commit_pend;
    logic          half_tick, full_tick;
    logic          cnt_clr, shift_en, stop_good, stop_bad;
    logic [2:0]    syn;
    logic [6:0]    flip, fixed;

    assign half_tick = (cnt == CW'(CLKS_PER_BIT / 2 - 1));
    assign full_tick = (cnt == CW'(CLKS_PER_BIT - 1));

    // Two-flop synchronizer, reset to the idle (high) line level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            line  <= 1'b1;
        end else begin
            sync1 <= serial_in;
            line  <= sync1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (armed && !line) state_d = START;
            START: if (half_tick) state_d = line ? IDLE : DATA;
            DATA:  if (full_tick && bit_idx == 3'd6) state_d = STOP;
            STOP:  if (full_tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: counter clear and mid-bit sample strobes
    always_comb begin
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            IDLE:  cnt_clr = 1'b1;
            START: cnt_clr = half_tick;
            DATA: begin
                cnt_clr  = full_tick;
                shift_en = full_tick;
            end
            STOP: begin
                cnt_clr   = full_tick;
                stop_good = full_tick && line;
                stop_bad  = full_tick && !line;
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    // Bit timing, deserializer and re-arm tracking after a framing error
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            bit_idx     <= '0;
            code        <= '0;
            armed       <= 1'b1;
            commit_pend <= 1'b0;
        end else begin
            cnt         <= cnt_clr ? '0 : cnt + CW'(1);
            commit_pend <= stop_good;
            if (state_q == START) bit_idx <= '0;
            if (shift_en) begin
                code[bit_idx] <= line;
                bit_idx       <= bit_idx + 3'd1;
            end
            if (stop_bad)  armed <= 1'b0;
            else if (line) armed <= 1'b1;
        end
    end

    // Syndrome and single-bit correction of the received codeword
    always_comb begin
        syn[0] = code[0] ^ code[2] ^ code[4] ^ code[6];
        syn[1] = code[1] ^ code[2] ^ code[5] ^ code[6];
        syn[2] = code[3] ^ code[4] ^ code[5] ^ code[6];
        flip   = '0;
        for (int unsigned i = 0; i < 7; i++)
            flip[i] = (syn == 3'(i + 1));
        fixed = code ^ flip;
    end

    // Output stage: commit one cycle after the stop sample, handshake, overrun, counter
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            syndrome   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            corr_count <= '0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;
            if (commit_pend) begin
                // Output slot is free if empty or being drained on this same edge
                if (!data_valid || data_ready) begin
                    data_out   <= {fixed[6], fixed[5], fixed[4], fixed[2]};
                    syndrome   <= syn;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
                if (syn != '0 && corr_count != '1)
                    corr_count <= corr_count + CNT_W'(1);
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Directed bench for hamming_serial_rx: clean and corrected frames,
// glitch and framing-error handling, overrun, coincident commit/transfer,
// counter saturation and mid-frame reset.
module tb_hamming_serial_rx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned FRAME = 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial_in = 1'b1;
    logic       data_ready = 1'b0;
    logic [3:0] data_out;
    logic [2:0] syndrome;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic [7:0] corr_count;

    int vectors = 0;
    int miscompares = 0;

    // Event log gathered on the falling edge
    int         xfer_cnt = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    int         dv_cycles = 0;
    logic [3:0] last_data = '0;
    logic [2:0] last_syn = '0;

    hamming_serial_rx #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .syndrome   (syndrome),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .corr_count (corr_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid && data_ready) begin
                xfer_cnt++;
                last_data = data_out;
                last_syn  = syndrome;
            end
            if (data_valid) dv_cycles++;
            if (frame_err)  ferr_cnt++;
            if (overrun)    ovr_cnt++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic p0, p1, p2;
        p0 = d[0] ^ d[1] ^ d[3];
        p1 = d[0] ^ d[2] ^ d[3];
        p2 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p2, d[0], p1, p0};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cycles(input logic [6:0] code, input logic stop, input int ncyc);
        logic [8:0] fr;
        fr = {stop, code, 1'b0};
        for (int c = 0; c < ncyc; c++) begin
            serial_in = fr[c / CPB];
            tick(1);
        end
    endtask

    task automatic send_frame(input logic [6:0] code, input logic stop);
        send_cycles(code, stop, FRAME);
        serial_in = 1'b1;
    endtask

    initial begin
        int         x0, f0, o0, d0;
        logic [6:0] cw;

        // Reset state
        rst = 1'b1;
        tick(3);
        chk("rst data_out", data_out, 4'h0);
        chk("rst syndrome", syndrome, 3'd0);
        chk("rst data_valid", data_valid, 1'b0);
        chk("rst frame_err", frame_err, 1'b0);
        chk("rst overrun", overrun, 1'b0);
        chk("rst corr_count", corr_count, 8'd0);
        rst = 1'b0;
        tick(2);

        // Clean frame with consumer ready
        data_ready = 1'b1;
        x0 = xfer_cnt;
        d0 = dv_cycles;
        send_frame(7'b1010101, 1'b1);
        tick(4);
        chk("clean xfer", xfer_cnt, x0 + 1);
        chk("clean data", last_data, 4'b1011);
        chk("clean syn", last_syn, 3'd0);
        chk("clean dv width", dv_cycles, d0 + 1);
        chk("clean corr", corr_count, 8'd0);
        chk("clean dv low", data_valid, 1'b0);

        // c4 flipped
        send_frame(7'b1000101, 1'b1);
        tick(4);
        chk("c4 data", last_data, 4'b1011);
        chk("c4 syn", last_syn, 3'd5);
        chk("c4 corr", corr_count, 8'd1);

        // Every data value, each single-bit flip plus the clean word
        for (int d = 0; d < 16; d++) begin
            for (int f = 0; f < 8; f++) begin
                cw = encode(4'(d));
                if (f < 7) cw[f] = ~cw[f];
                send_frame(cw, 1'b1);
                tick(4);
                chk($sformatf("sweep d%0d f%0d data", d, f), last_data, 32'(d));
                chk($sformatf("sweep d%0d f%0d syn", d, f), last_syn, (f < 7) ? 32'(f + 1) : 32'd0);
            end
        end
        chk("sweep corr", corr_count, 8'd113);

        // One-cycle low glitch on the idle line
        x0 = xfer_cnt;
        f0 = ferr_cnt;
        serial_in = 1'b0;
        tick(1);
        serial_in = 1'b1;
        tick(12);
        chk("glitch xfer", xfer_cnt, x0);
        chk("glitch ferr", ferr_cnt, f0);
        chk("glitch dv", data_valid, 1'b0);

        // Bad stop bit, then recovery
        send_frame(encode(4'h5), 1'b0);
        tick(4);
        chk("ferr pulse", ferr_cnt, f0 + 1);
        chk("ferr no xfer", xfer_cnt, x0);
        send_frame(encode(4'hC), 1'b1);
        tick(4);
        chk("recover data", last_data, 4'hC);
        chk("recover xfer", xfer_cnt, x0 + 1);
        chk("recover ferr", ferr_cnt, f0 + 1);

        // Overrun with consumer stalled, back-to-back frames
        data_ready = 1'b0;
        x0 = xfer_cnt;
        o0 = ovr_cnt;
        send_frame(7'b1010101, 1'b1);
        send_frame(7'b0000000, 1'b1);
        tick(4);
        chk("ovr dv held", data_valid, 1'b1);
        chk("ovr data held", data_out, 4'b1011);
        chk("ovr syn held", syndrome, 3'd0);
        chk("ovr pulse", ovr_cnt, o0 + 1);
        chk("ovr no xfer", xfer_cnt, x0);
        data_ready = 1'b1;
        tick(1);
        chk("ovr drain dv", data_valid, 1'b0);
        chk("ovr drain data", last_data, 4'b1011);
        chk("ovr drain xfer", xfer_cnt, x0 + 1);
        chk("ovr single", ovr_cnt, o0 + 1);

        // Transfer coinciding with the second commit (commit edge is 2 edges after the frame)
        data_ready = 1'b0;
        send_frame(7'b1010101, 1'b1);
        tick(4);
        chk("coinc first dv", data_valid, 1'b1);
        o0 = ovr_cnt;
        send_frame(7'b0000000, 1'b1);
        tick(1);
        data_ready = 1'b1;
        tick(1);
        chk("coinc dv", data_valid, 1'b1);
        chk("coinc data", data_out, 4'b0000);
        chk("coinc no ovr", ovr_cnt, o0);
        tick(1);
        chk("coinc drain dv", data_valid, 1'b0);
        chk("coinc drain data", last_data, 4'b0000);
        chk("coinc corr", corr_count, 8'd113);

        // Counter saturation
        for (int i = 0; i < 260; i++) begin
            cw = encode(4'hA);
            cw[i % 7] = ~cw[i % 7];
            send_frame(cw, 1'b1);
        end
        tick(4);
        chk("sat corr", corr_count, 8'd255);
        chk("sat data", data_out, 4'hA);
        chk("sat syn", syndrome, 3'd1);
        chk("sat dv", data_valid, 1'b0);

        // Reset in the middle of a frame
        f0 = ferr_cnt;
        send_cycles(encode(4'h3), 1'b1, 16);
        rst = 1'b1;
        serial_in = 1'b1;
        tick(1);
        chk("midrst data", data_out, 4'h0);
        chk("midrst syn", syndrome, 3'd0);
        chk("midrst dv", data_valid, 1'b0);
        chk("midrst corr", corr_count, 8'd0);
        rst = 1'b0;
        tick(4);
        x0 = xfer_cnt;
        send_frame(encode(4'h6), 1'b1);
        tick(4);
        chk("post rst data", last_data, 4'h6);
        chk("post rst syn", last_syn, 3'd0);
        chk("post rst xfer", xfer_cnt, x0 + 1);
        chk("post rst corr", corr_count, 8'd0);
        chk("post rst ferr", ferr_cnt, f0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hamming_serial_rx.md
Name: hamming_serial_rx

Overview:
Serial receive end of the Hamming(7,4) link. It deserializes UART-style framed 7-bit codewords from a single input line and computes the syndrome. It corrects any single-bit error and presents the 4-bit data nibble with a valid/ready handshake. It also flags framing errors and overruns and keeps a saturating count of corrected words.

Parameters:
- CLKS_PER_BIT, 4, clk cycles per serial bit. Must be even and at least 4.
- CNT_W, 8, width of the corrected-word counter.

Ports:
- clk  input  1  clock. All logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- serial_in  input  1  serial line. Idle is high.
- data_out  output  4  corrected data nibble {d3,d2,d1,d0}.
- syndrome  output  3  syndrome of the presented word. 0 means no error.
- data_valid  output  1  data_out and syndrome are valid.
- data_ready  input  1  consumer accepts the word.
- frame_err  output  1  one-cycle pulse when a bad stop bit is sampled.
- overrun  output  1  one-cycle pulse when a word is dropped.
- corr_count  output  CNT_W  number of words with a nonzero syndrome. Saturates.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE and the bit-timing counter clears.
  - data_out=0, syndrome=0, data_valid=0, frame_err=0, overrun=0, corr_count=0.
  - The synchronizer flops are set to 1.
  - Reset mid-frame discards the partial frame.
- Input sync: serial_in passes through 2 flops. All references to "line" below mean the synchronized signal.
- Frame format: start bit (0), then c0..c6 LSB first, then stop bit (1). Each bit lasts CLKS_PER_BIT cycles.
- Code layout (bit index = Hamming position-1): c0=p0, c1=p1, c2=d0, c3=p2, c4=d1, c5=d2, c6=d3.
  - p0 = d0^d1^d3
  - p1 = d0^d2^d3
  - p2 = d1^d2^d3
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when line=0, go to START and clear the bit-timing counter.
  - START: wait CLKS_PER_BIT/2 cycles, then sample the line at mid-bit.
    - Line=1: glitch. Go to IDLE with no pulse.
    - Line=0: go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles. Shift the bit into position c[bit_idx], with bit_idx running 0..6. After c6, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Line=0: pulse frame_err for 1 cycle, discard the word, go to IDLE. IDLE does not re-arm until the line has been seen high at least once.
    - Line=1: commit the word (see below) and go to IDLE.
- Decode:
  - s0 = c0^c2^c4^c6
  - s1 = c1^c2^c5^c6
  - s2 = c3^c4^c5^c6
  - syndrome = {s2,s1,s0}. If syndrome≠0, invert c[syndrome-1].
  - data_out = {c6,c5,c4,c2} after correction.
  - Double-bit errors are miscorrected; no detection is required.
- Commit:
  - Takes effect in the cycle after the stop-bit sample: data_valid=1 and the output registers load.
  - If syndrome≠0, corr_count increments, holding at all-ones.
- Handshake:
  - A transfer occurs on any edge where data_valid=1 and data_ready=1. data_valid drops the next cycle unless a new commit happens in that same cycle.
  - data_out and syndrome stay stable while data_valid=1 and data_ready=0.
- Overrun: a commit while data_valid=1 and data_ready=0 keeps the old word, drops the new one, and pulses overrun. corr_count still counts the dropped word if its syndrome is nonzero.
- Simultaneous commit and transfer: the new word loads, data_valid stays 1, and overrun does not pulse.
- Latency: from the line falling at the start bit to data_valid rising is 2 (sync) + 8.5×CLKS_PER_BIT + 1 cycles, ±1.
- Back-to-back frames, with the next start bit immediately after the stop bit, must be received with no loss.

Test Plan:
- Reset, then send a clean frame of codeword 7'b1010101 (data 4'b1011) with data_ready=1 → data_out=4'b1011, syndrome=0, one-cycle data_valid, corr_count=0.
- Send 7'b1000101 (c4 flipped) → data_out=4'b1011, syndrome=3'd5, corr_count=1. Repeat with each of the 7 single-bit flips of every data value 0..15 → data is always correct and the syndrome equals bit index+1.
- Drive a 1-cycle low glitch on the idle line → no data_valid and no frame_err. Send a frame with stop bit=0 → frame_err pulses once, no data_valid, the receiver recovers on the next good frame.
- Hold data_ready=0 and send 2 frames (0x55, then 7'b0000000) → data_out stays 4'b1011, overrun pulses once at the 2nd commit. Raise data_ready → 4'b1011 transfers and data_valid drops.
- Time data_ready=1 to coincide with the 2nd commit cycle → no overrun, data_out=4'b0000, data_valid stays high.
- Send 260 corrupted frames → corr_count saturates at 255. Assert rst mid-frame → all outputs 0 and the next frame decodes correctly.
